// File: rtl/cache_data_array_2p_if.sv
// Request/response bundle for the two-port cache data array.
// Port 0 is read/write and port 1 is read-only. The master side drives the requests.
interface cache_data_array_2p_if #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 32
) ();
    logic                  ready;
    logic                  csb0;
    logic                  web0;
    logic [NUM_WMASKS-1:0] wmask0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;
    logic                  dout0_valid;
    logic                  csb1;
    logic [ADDR_WIDTH-1:0] addr1;
    logic [DATA_WIDTH-1:0] dout1;
    logic                  dout1_valid;

    modport master (
        input  ready, dout0, dout0_valid, dout1, dout1_valid,
        output csb0, web0, wmask0, addr0, din0, csb1, addr1
    );

    modport slave (
        input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
        output ready, dout0, dout0_valid, dout1, dout1_valid
    );
endinterface

// File: rtl/cache_data_array_2p.sv
// Two-port cache data array. Port 0 reads or writes with byte-lane masks, and port 1 only reads.
// Port 1 reads forward same-edge port 0 writes (write-first). Zero-fill after reset is optional.
module cache_data_array_2p #(
    parameter int DATA_WIDTH = 256,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_WMASKS = 32,
    parameter int OUT_REG    = 0,
    parameter int INIT_ZERO  = 1
) (
    input  logic                 clk0,
    input  logic                 rst0_n,
    cache_data_array_2p_if.slave bus
);
    localparam int RAM_DEPTH  = 2**ADDR_WIDTH;
    localparam int LANE_WIDTH = DATA_WIDTH / NUM_WMASKS;
    localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(RAM_DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic                  w_initWe;
    logic                  r_ready;
    logic [ADDR_WIDTH:0]   r_initCnt;

    logic                  w_acc0;
    logic                  w_acc1;
    logic                  r_p0Pending;
    logic                  r_p0Write;
    logic                  r_p1Pending;
    logic [NUM_WMASKS-1:0] r_wmask0;
    logic [ADDR_WIDTH-1:0] r_addr0;
    logic [ADDR_WIDTH-1:0] r_addr1;
    logic [DATA_WIDTH-1:0] r_din0;

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] w_bitMask;
    logic [DATA_WIDTH-1:0] w_rdWord0;
    logic [DATA_WIDTH-1:0] w_rdWord1;
    logic [DATA_WIDTH-1:0] w_fwdWord1;
    logic                  w_collide;
    logic                  w_rdEn0;

    logic                  r_q0Valid;
    logic                  r_q1Valid;
    logic [DATA_WIDTH-1:0] r_q0;
    logic [DATA_WIDTH-1:0] r_q1;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            if (INIT_ZERO != 0) r_state <= INIT;
            else                r_state <= RUN;
            r_initCnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_ready <= (w_nextState == RUN);
            if (w_initWe) r_initCnt <= r_initCnt + 1'b1;
        end
    end

    // The sweep clears one word per cycle. The edge that clears the last word also raises ready.
    always_comb begin
        w_nextState = r_state;
        w_initWe    = 1'b0;
        case (r_state)
            INIT: begin
                w_initWe = 1'b1;
                if (r_initCnt == LAST_ADDR) w_nextState = RUN;
            end
            RUN: w_nextState = RUN;
        endcase
    end

    assign w_acc0 = r_ready && !bus.csb0;
    assign w_acc1 = r_ready && !bus.csb1;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_p0Pending <= 1'b0;
            r_p0Write   <= 1'b0;
            r_p1Pending <= 1'b0;
            r_wmask0    <= '0;
            r_addr0     <= '0;
            r_addr1     <= '0;
            r_din0      <= '0;
        end else begin
            r_p0Pending <= w_acc0;
            r_p1Pending <= w_acc1;
            if (w_acc0) begin
                r_p0Write <= !bus.web0;
                r_wmask0  <= bus.wmask0;
                r_addr0   <= bus.addr0;
                r_din0    <= bus.din0;
            end
            if (w_acc1) r_addr1 <= bus.addr1;
        end
    end

    for (genvar g = 0; g < NUM_WMASKS; g++) begin : g_lane
        assign w_bitMask[g*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{r_wmask0[g]}};
    end

    always_ff @(posedge clk0) begin
        if (w_initWe)
            r_mem[r_initCnt[ADDR_WIDTH-1:0]] <= '0;
        else if (r_p0Pending && r_p0Write)
            r_mem[r_addr0] <= (r_mem[r_addr0] & ~w_bitMask) | (r_din0 & w_bitMask);
    end

    // The array still holds the pre-write word here, so merge in the write that commits on this edge.
    assign w_rdWord0  = r_mem[r_addr0];
    assign w_rdWord1  = r_mem[r_addr1];
    assign w_rdEn0    = r_p0Pending && !r_p0Write;
    assign w_collide  = r_p1Pending && r_p0Pending && r_p0Write && (r_addr0 == r_addr1);
    assign w_fwdWord1 = w_collide ? ((w_rdWord1 & ~w_bitMask) | (r_din0 & w_bitMask)) : w_rdWord1;

    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            r_q0Valid <= 1'b0;
            r_q1Valid <= 1'b0;
            r_q0      <= '0;
            r_q1      <= '0;
        end else begin
            r_q0Valid <= w_rdEn0;
            r_q1Valid <= r_p1Pending;
            if (w_rdEn0)     r_q0 <= w_rdWord0;
            if (r_p1Pending) r_q1 <= w_fwdWord1;
        end
    end

    if (OUT_REG != 0) begin : g_outReg
        logic                  r_o0Valid;
        logic                  r_o1Valid;
        logic [DATA_WIDTH-1:0] r_o0;
        logic [DATA_WIDTH-1:0] r_o1;

        always_ff @(posedge clk0 or negedge rst0_n) begin
            if (!rst0_n) begin
                r_o0Valid <= 1'b0;
                r_o1Valid <= 1'b0;
                r_o0      <= '0;
                r_o1      <= '0;
            end else begin
                r_o0Valid <= r_q0Valid;
                r_o1Valid <= r_q1Valid;
                if (r_q0Valid) r_o0 <= r_q0;
                if (r_q1Valid) r_o1 <= r_q1;
            end
        end

        assign bus.dout0       = r_o0;
        assign bus.dout0_valid = r_o0Valid;
        assign bus.dout1       = r_o1;
        assign bus.dout1_valid = r_o1Valid;
    end else begin : g_noOutReg
        assign bus.dout0       = r_q0;
        assign bus.dout0_valid = r_q0Valid;
        assign bus.dout1       = r_q1;
        assign bus.dout1_valid = r_q1Valid;
    end

    assign bus.ready = r_ready;
endmodule
